// File: rtl/booth_pkg.sv
// Shared definitions for the radix-8 Booth recoder: digit-count helper,
// digit magnitude encoding and the window-to-magnitude decode function.
package booth_pkg;

    typedef enum logic [2:0] {
        MAG_ZERO  = 3'd0,
        MAG_ONE   = 3'd1,
        MAG_TWO   = 3'd2,
        MAG_THREE = 3'd3,
        MAG_FOUR  = 3'd4
    } booth_mag_e;

    localparam int unsigned BOOTH_WINDOW_W = 4;

    function automatic int num_partials(input int width);
        return (width + 2) / 3;
    endfunction

    // Window {b3,b2,b1,b0} carries weight -4*b3 + 2*b2 + b1 + b0; return |digit|.
    function automatic booth_mag_e window_mag(input logic [3:0] win);
        booth_mag_e mag;
        case (win)
            4'b0000: mag = MAG_ZERO;
            4'b0001: mag = MAG_ONE;
            4'b0010: mag = MAG_ONE;
            4'b0011: mag = MAG_TWO;
            4'b0100: mag = MAG_TWO;
            4'b0101: mag = MAG_THREE;
            4'b0110: mag = MAG_THREE;
            4'b0111: mag = MAG_FOUR;
            4'b1000: mag = MAG_FOUR;
            4'b1001: mag = MAG_THREE;
            4'b1010: mag = MAG_THREE;
            4'b1011: mag = MAG_TWO;
            4'b1100: mag = MAG_TWO;
            4'b1101: mag = MAG_ONE;
            4'b1110: mag = MAG_ONE;
            4'b1111: mag = MAG_ZERO;
            default: mag = MAG_ZERO;
        endcase
        return mag;
    endfunction

endpackage

// File: rtl/booth_r8_digit_enc.sv
// Combinational radix-8 Booth digit encoder: one 4-bit window in,
// one-hot magnitude selects {s,d,t,q} plus negative flag n out.
module booth_r8_digit_enc
    import booth_pkg::*;
(
    input  logic [3:0] win,
    output logic       s,
    output logic       d,
    output logic       t,
    output logic       q,
    output logic       n
);

    booth_mag_e mag_s;

    // Decode window into one-hot magnitude selects and sign.
    always_comb begin
        mag_s = window_mag(win);
        s     = 1'b0;
        d     = 1'b0;
        t     = 1'b0;
        q     = 1'b0;
        case (mag_s)
            MAG_ONE:   s = 1'b1;
            MAG_TWO:   d = 1'b1;
            MAG_THREE: t = 1'b1;
            MAG_FOUR:  q = 1'b1;
            default: begin
                s = 1'b0;
            end
        endcase
        // 1111 is a zero digit, so it must not report negative.
        n = win[3] & ~(win[2] & win[1] & win[0]);
    end

endmodule

// File: rtl/booth_recoding.sv
// Registered radix-8 Booth recoder of a signed DATA_WIDTH operand.
// Optional per-digit zero flag output z enabled by BOOTH_ZERO_FLAG_EN.
module booth_recoding
    import booth_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    localparam int NUM_PARTIALS = num_partials(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   X,
    output logic [NUM_PARTIALS-1:0] s,
    output logic [NUM_PARTIALS-1:0] d,
    output logic [NUM_PARTIALS-1:0] t,
    output logic [NUM_PARTIALS-1:0] q,
`ifdef BOOTH_ZERO_FLAG_EN
    output logic [NUM_PARTIALS-1:0] z,
`endif
    output logic [NUM_PARTIALS-1:0] n
);

    localparam int EXT_W = 3 * NUM_PARTIALS + 1;

    logic [EXT_W-1:0]        ext_s;
    logic [NUM_PARTIALS-1:0] s_s, d_s, t_s, q_s, n_s;
    logic [NUM_PARTIALS-1:0] s_d, d_d, t_d, q_d, n_d;
    logic [NUM_PARTIALS-1:0] s_q, d_q, t_q, q_q, n_q;
`ifdef BOOTH_ZERO_FLAG_EN
    logic [NUM_PARTIALS-1:0] z_d, z_q;
`endif

    // Sign-extend X to whole digits and append the implicit zero at bit -1.
    always_comb begin
        ext_s    = '0;
        ext_s[0] = 1'b0;
        for (int j = 0; j < 3 * NUM_PARTIALS; j++) begin
            if (j < DATA_WIDTH) begin
                ext_s[j+1] = X[j];
            end else begin
                ext_s[j+1] = X[DATA_WIDTH-1];
            end
        end
    end

    for (genvar i = 0; i < NUM_PARTIALS; i++) begin : g_digit
        booth_r8_digit_enc u_enc (
            .win (ext_s[3*i+3:3*i]),
            .s   (s_s[i]),
            .d   (d_s[i]),
            .t   (t_s[i]),
            .q   (q_s[i]),
            .n   (n_s[i])
        );
    end

    // Next-state values for the output registers.
    always_comb begin
        s_d = s_s;
        d_d = d_s;
        t_d = t_s;
        q_d = q_s;
        n_d = n_s;
`ifdef BOOTH_ZERO_FLAG_EN
        z_d = ~(s_s | d_s | t_s | q_s);
`endif
    end

    // Output registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= '0;
            d_q <= '0;
            t_q <= '0;
            q_q <= '0;
            n_q <= '0;
`ifdef BOOTH_ZERO_FLAG_EN
            z_q <= '0;
`endif
        end else begin
            s_q <= s_d;
            d_q <= d_d;
            t_q <= t_d;
            q_q <= q_d;
            n_q <= n_d;
`ifdef BOOTH_ZERO_FLAG_EN
            z_q <= z_d;
`endif
        end
    end

    assign s = s_q;
    assign d = d_q;
    assign t = t_q;
    assign q = q_q;
    assign n = n_q;
`ifdef BOOTH_ZERO_FLAG_EN
    assign z = z_q;
`endif

endmodule

// File: tb/tb_booth_recoding.sv
// Self-checking bench for booth_recoding (DATA_WIDTH = 8): directed vectors,
// reset behaviour, exhaustive sweep and random stimulus against a digit model.
module tb_booth_recoding;

    localparam int DW = 8;
    localparam int NP = (DW + 2) / 3;

    logic          clk;
    logic          rst;
    logic [DW-1:0] X;
    logic [NP-1:0] s, d, t, q, n;
`ifdef BOOTH_ZERO_FLAG_EN
    logic [NP-1:0] z;
`endif

    int passed;
    int total;

    booth_recoding #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .X   (X),
        .s   (s),
        .d   (d),
        .t   (t),
        .q   (q),
`ifdef BOOTH_ZERO_FLAG_EN
        .z   (z),
`endif
        .n   (n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Bit j of X sign-extended to infinity, with bit -1 defined as zero.
    function automatic int xbit(input longint xv, input int j);
        if (j < 0) return 0;
        return int'((xv >>> j) & 64'sd1);
    endfunction

    function automatic int digit(input longint xv, input int i);
        return -4 * xbit(xv, 3*i+2) + 2 * xbit(xv, 3*i+1) + xbit(xv, 3*i) + xbit(xv, 3*i-1);
    endfunction

    task automatic check_all(input string tag, input logic [DW-1:0] xv);
        longint        xs;
        logic [NP-1:0] es, ed, et, eq, en;
        longint        sum;
        longint        w;
        int            dg, mag, cnt;
        xs = longint'($signed(xv));
        es = '0; ed = '0; et = '0; eq = '0; en = '0;
        for (int i = 0; i < NP; i++) begin
            dg  = digit(xs, i);
            mag = (dg < 0) ? -dg : dg;
            es[i] = (mag == 1);
            ed[i] = (mag == 2);
            et[i] = (mag == 3);
            eq[i] = (mag == 4);
            en[i] = (dg < 0);
        end
        check({tag, ".s"}, 64'(s), 64'(es));
        check({tag, ".d"}, 64'(d), 64'(ed));
        check({tag, ".t"}, 64'(t), 64'(et));
        check({tag, ".q"}, 64'(q), 64'(eq));
        check({tag, ".n"}, 64'(n), 64'(en));
`ifdef BOOTH_ZERO_FLAG_EN
        check({tag, ".z"}, 64'(z), 64'(~(s | d | t | q)));
`endif
        // Rebuild X from the DUT's own digits.
        sum = 0;
        w   = 1;
        cnt = 0;
        for (int i = 0; i < NP; i++) begin
            mag = s[i] ? 1 : d[i] ? 2 : t[i] ? 3 : q[i] ? 4 : 0;
            if (int'(s[i]) + int'(d[i]) + int'(t[i]) + int'(q[i]) > 1) cnt++;
            sum = sum + (n[i] ? -mag : mag) * w;
            w   = w * 8;
        end
        check({tag, ".sum"}, 64'(sum), 64'(xs));
        check({tag, ".onehot"}, 64'(cnt), 64'd0);
    endtask

    task automatic step(input string tag, input logic [DW-1:0] xv);
        X = xv;
        @(posedge clk);
        #1;
        check_all(tag, xv);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".s"}, 64'(s), 64'd0);
        check({tag, ".d"}, 64'(d), 64'd0);
        check({tag, ".t"}, 64'(t), 64'd0);
        check({tag, ".q"}, 64'(q), 64'd0);
        check({tag, ".n"}, 64'(n), 64'd0);
`ifdef BOOTH_ZERO_FLAG_EN
        check({tag, ".z"}, 64'(z), 64'd0);
`endif
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b0;
        X      = DW'($urandom);
        #2;
        check_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");

        @(negedge clk);
        rst = 1'b1;
        // Directed vectors with explicitly known answers.
        step("x7", 8'd7);
        check("x7.lit_s", 64'(s), 64'h3);
        check("x7.lit_n", 64'(n), 64'h1);
        step("x4", 8'd4);
        check("x4.lit_q", 64'(q), 64'h1);
        check("x4.lit_s", 64'(s), 64'h2);
        step("x3", 8'd3);
        check("x3.lit_t", 64'(t), 64'h1);
        step("xm128", 8'h80);
        check("xm128.lit_d", 64'(d), 64'h4);
        check("xm128.lit_n", 64'(n), 64'h4);
        step("xm1", 8'hFF);
        check("xm1.lit_s", 64'(s), 64'h1);
        check("xm1.lit_n", 64'(n), 64'h1);

        // Back-to-back and stability between edges.
        step("b2b7", 8'd7);
        X = 8'd4;
        #2;
        check("hold.s", 64'(s), 64'h3);
        step("b2b4", 8'd4);
        step("b2b3", 8'd3);

        // Mid-stream reset clears outputs before the next edge.
        X = 8'hFF;
        #2;
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        check_zero("rst_mid_edge");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 8'd7);

        for (int v = 0; v < 256; v++) begin
            step("sweep", DW'(v));
        end
        for (int k = 0; k < 200; k++) begin
            step("rand", DW'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
